// File: rtl/div_result_fifo_pkg.sv
// div_result_fifo_pkg: register map, STATUS/CTRL bit positions and entry layout helpers
//   Register offsets are word indices (wbs_adr_i[3:2]) inside the 16-byte window.
//   A FIFO entry is packed as {dbz, rem, quot}: quot in the low XLEN bits,
//   rem in the next XLEN bits, dbz in the top bit.
package div_result_fifo_pkg;
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_QUOT   = 2'd1;
    localparam logic [1:0] REG_REM    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_DBZ     = 3;
    localparam int ST_CNT_LSB = 8;
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;
    function automatic int entry_w(input int xlen);
        return 2 * xlen + 1;
    endfunction
endpackage

// File: rtl/div_result_fifo_sync_fifo.sv
// sync_fifo: generic synchronous FIFO with push, pop and flush
//   clk, rst      clock and asynchronous active-high reset
//   push/din      write request and data (dropped when full unless popping)
//   pop           read request (ignored when empty)
//   flush         clears pointers and count; wins over push and pop
//   dout          head entry (first-word fall-through)
//   count/full/empty  occupancy status
module sync_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & !empty & !flush;
    // Full is judged after the pop, so a simultaneous pop frees the slot.
    assign do_push = push & !flush & (!full | do_pop);
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/div_result_fifo.sv
// div_result_fifo: buffers divider results and exposes them through a Wishbone slave window
//   clk_i, reset_i        clock and asynchronous active-high reset
//   res_valid_i/quot/rem/dbz  one-cycle result pulse from the divider
//   wbs_*                 Wishbone slave (STATUS, QUOT, REM-with-pop, CTRL)
//   full_o                FIFO full
//   irq_o                 level interrupt while the FIFO holds entries
module div_result_fifo
    import div_result_fifo_pkg::*;
#(
    parameter int             WBW      = 32,
    parameter int             XLEN     = 32,
    parameter int             DEPTH    = 4,
    parameter logic [WBW-1:0] BASE_ADR = 32'h3000_0100
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               res_valid_i,
    input  logic [XLEN-1:0]    res_quot_i,
    input  logic [XLEN-1:0]    res_rem_i,
    input  logic               res_dbz_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [WBW/8-1:0]   wbs_sel_i,
    input  logic [WBW-1:0]     wbs_adr_i,
    input  logic [WBW-1:0]     wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [WBW-1:0]     wbs_dat_o,
    output logic               full_o,
    output logic               irq_o
);
    localparam int EW = entry_w(XLEN);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [EW-1:0]  head;
    logic [CW-1:0]  count;
    logic           full, empty, ovf;
    logic           hit, mapped, is_read, ctrl_wr, pop, flush, clr_ovf, ovf_set;
    logic [1:0]     reg_sel;
    logic [WBW-1:0] status, rdata;
    logic           unused;
    assign unused  = ^{wbs_sel_i[WBW/8-1:1], wbs_dat_i[WBW-1:2]};
    // The !ack term forces the one-cycle gap between back-to-back acks.
    assign hit     = wbs_stb_i & wbs_cyc_i & !wbs_ack_o & (wbs_adr_i[WBW-1:4] == BASE_ADR[WBW-1:4]);
    assign mapped  = wbs_adr_i[1:0] == 2'b00;
    assign reg_sel = wbs_adr_i[3:2];
    assign is_read = hit & !wbs_we_i;
    assign ctrl_wr = hit & wbs_we_i & mapped & (reg_sel == REG_CTRL) & wbs_sel_i[0];
    // Pop on the same edge that registers ack and read data, so the data is the pre-pop head.
    assign pop     = is_read & mapped & (reg_sel == REG_REM);
    assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign clr_ovf = ctrl_wr & wbs_dat_i[CTRL_CLR_OVF];
    // A result is lost only when no slot frees this cycle; a flush discards it silently.
    assign ovf_set = res_valid_i & full & !(pop & !empty) & !flush;
    assign full_o  = full;
    assign irq_o   = !empty;
    sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (res_valid_i),
        .pop   (pop),
        .flush (flush),
        .din   ({res_dbz_i, res_rem_i, res_quot_i}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_comb begin
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL] = full;
        status[ST_OVF] = ovf;
        status[ST_DBZ] = !empty & head[EW-1];
        status[ST_CNT_LSB +: 8] = 8'(count);
    end
    always_comb begin
        rdata = !mapped ? '0 :
                reg_sel == REG_STATUS ? status :
                empty ? '0 :
                reg_sel == REG_QUOT ? WBW'(head[XLEN-1:0]) :
                reg_sel == REG_REM ? WBW'(head[2*XLEN-1:XLEN]) : '0;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            wbs_dat_o <= is_read ? rdata : '0;
            ovf       <= ovf_set ? 1'b1 : clr_ovf ? 1'b0 : ovf;
        end
    end
endmodule

// File: tb/tb_div_result_fifo.sv
// tb_div_result_fifo: directed self-checking bench for div_result_fifo
module tb_div_result_fifo;
    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] A_STATUS = BASE + 32'h0;
    localparam logic [31:0] A_QUOT   = BASE + 32'h4;
    localparam logic [31:0] A_REM    = BASE + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE + 32'hC;
    logic        clk_i = 1'b0, reset_i = 1'b1;
    logic        res_valid_i = 1'b0, res_dbz_i = 1'b0;
    logic [31:0] res_quot_i = '0, res_rem_i = '0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o, full_o, irq_o;
    logic [31:0] wbs_dat_o;
    int          checks = 0, failures = 0;
    logic [31:0] rd;

    div_result_fifo dut (
        .clk_i(clk_i), .reset_i(reset_i), .res_valid_i(res_valid_i),
        .res_quot_i(res_quot_i), .res_rem_i(res_rem_i), .res_dbz_i(res_dbz_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .full_o(full_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] q, input logic [31:0] r, input logic z);
        @(negedge clk_i);
        res_valid_i = 1'b1; res_quot_i = q; res_rem_i = r; res_dbz_i = z;
        @(negedge clk_i);
        res_valid_i = 1'b0;
    endtask

    // Optionally pulses a divider result on the same edge as the request is accepted.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic co_valid, input logic [31:0] q, input logic [31:0] r,
                           output logic [31:0] data);
        bit got = 0;
        data = '0;
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we; wbs_sel_i = 4'hF;
        wbs_adr_i = adr; wbs_dat_i = wdat;
        res_valid_i = co_valid; res_quot_i = q; res_rem_i = r; res_dbz_i = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk_i); #1;
            res_valid_i = 1'b0;
            if (wbs_ack_o) begin
                got = 1;
                data = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, adr, '0, 1'b0, '0, '0, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] d;
        wb_xfer(1'b1, adr, wdat, 1'b0, '0, '0, d);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_full_irq", {30'd0, full_o, irq_o}, 32'd0);
        reset_i = 1'b0;
        rd_chk("rst_status", A_STATUS, 32'h0000_0001);
        // 1) 7/2
        push(32'd3, 32'd1, 1'b0);
        chk("t1_irq", {31'd0, irq_o}, 32'd1);
        rd_chk("t1_status", A_STATUS, 32'h0000_0100);
        rd_chk("t1_quot", A_QUOT, 32'd3);
        rd_chk("t1_rem", A_REM, 32'd1);
        rd_chk("t1_status_after", A_STATUS, 32'h0000_0001);
        chk("t1_irq_after", {31'd0, irq_o}, 32'd0);
        // 2) fill to full, then overflow
        push(32'd14, 32'd2, 1'b0);
        push(32'd3, 32'd0, 1'b0);
        push(32'd1, 32'd0, 1'b0);
        chk("t2_not_full3", {31'd0, full_o}, 32'd0);
        push(32'd2, 32'd2, 1'b0);
        chk("t2_full4", {31'd0, full_o}, 32'd1);
        push(32'd1, 32'd1, 1'b0);
        rd_chk("t2_status_ovf", A_STATUS, 32'h0000_0406);
        rd_chk("t2_q0", A_QUOT, 32'd14);
        rd_chk("t2_r0", A_REM, 32'd2);
        rd_chk("t2_q1", A_QUOT, 32'd3);
        rd_chk("t2_r1", A_REM, 32'd0);
        rd_chk("t2_q2", A_QUOT, 32'd1);
        rd_chk("t2_r2", A_REM, 32'd0);
        rd_chk("t2_q3", A_QUOT, 32'd2);
        rd_chk("t2_r3", A_REM, 32'd2);
        rd_chk("t2_status_empty", A_STATUS, 32'h0000_0005);
        wr(A_CTRL, 32'h2);
        rd_chk("t2_status_clr", A_STATUS, 32'h0000_0001);
        // 3) divide by zero
        push(32'hFFFF_FFFF, 32'd9, 1'b1);
        rd_chk("t3_status", A_STATUS, 32'h0000_0108);
        rd_chk("t3_quot", A_QUOT, 32'hFFFF_FFFF);
        rd_chk("t3_rem", A_REM, 32'd9);
        rd_chk("t3_status_after", A_STATUS, 32'h0000_0001);
        // 4) pop and push together while full
        for (int k = 10; k < 14; k++) push(32'(k), 32'(k + 100), 1'b0);
        wb_xfer(1'b0, A_REM, '0, 1'b1, 32'd20, 32'd21, rd);
        chk("t4_rem_head", rd, 32'd110);
        rd_chk("t4_status", A_STATUS, 32'h0000_0402);
        rd_chk("t4_q1", A_QUOT, 32'd11);
        rd_chk("t4_r1", A_REM, 32'd111);
        rd_chk("t4_r2", A_REM, 32'd112);
        rd_chk("t4_r3", A_REM, 32'd113);
        rd_chk("t4_q4", A_QUOT, 32'd20);
        rd_chk("t4_r4", A_REM, 32'd21);
        rd_chk("t4_status_after", A_STATUS, 32'h0000_0001);
        // 5) flush with a coincident result, overflow preserved
        for (int k = 0; k < 5; k++) push(32'(k), 32'(k), 1'b0);
        wb_xfer(1'b1, A_CTRL, 32'h1, 1'b1, 32'd77, 32'd78, rd);
        rd_chk("t5_status", A_STATUS, 32'h0000_0005);
        rd_chk("t5_rem_empty", A_REM, 32'd0);
        rd_chk("t5_status_after", A_STATUS, 32'h0000_0005);
        wr(A_CTRL, 32'h2);
        // 6) reset during a held read strobe
        push(32'd5, 32'd6, 1'b0);
        @(negedge clk_i);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_QUOT;
        #2 reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("t6_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        end
        chk("t6_dat", wbs_dat_o, 32'd0);
        chk("t6_full_irq", {30'd0, full_o, irq_o}, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        rd_chk("t6_status", A_STATUS, 32'h0000_0001);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
